qpsk_symbol_packer: RTL
=======================

// Module: qpsk_symbol_packer
// PURPOSE
//  Upstream stage of the QPSK modulator. Accepts a serial payload bit stream,
//  prepends a fixed preamble to every frame and packs bits into 2-bit symbols.
//  Output m_dibit drives the modulator's 2-bit data_in; m_valid/m_ready pace symbols.
// PARAMETERS
//  PREAMBLE_SYMS  4     preamble dibits per frame, 1..15; alternates 2'b00,2'b11, starting 2'b00
//  MSB_FIRST      1     1: first bit of a pair -> dibit[1]; 0: first bit -> dibit[0]
//  FCNT_W         16    width of frame counter
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       synchronous, active-high
//  s_valid    in   1       input bit valid
//  s_ready    out  1       packer accepts s_bit this cycle
//  s_bit      in   1       payload bit
//  s_last     in   1       s_bit is last bit of frame
//  m_valid    out  1       m_dibit valid
//  m_ready    in   1       downstream accepts symbol
//  m_dibit    out  2       symbol to modulator data_in
//  m_last     out  1       final payload symbol of frame
//  m_pre      out  1       current symbol is preamble
//  frame_cnt  out  FCNT_W  completed frames, wraps at 2^FCNT_W
// BEHAVIOUR
//  Reset: s_ready=0, m_valid=0, m_dibit=0, m_last=0, m_pre=0, frame_cnt=0, state IDLE,
//   half-bit register cleared, preamble counter 0. Reset mid-frame drops partial bit and pending symbol.
//  Transfer on valid&ready, both sides. m_valid, m_dibit, m_last, m_pre held stable until m_ready.
//  Output slot free = !m_valid || m_ready (single output register, full throughput).
//  FSM IDLE: s_ready=0; s_valid=1 -> PREAMBLE (bit not consumed).
//  FSM PREAMBLE: when slot free, load preamble dibit, m_pre=1, count++; after PREAMBLE_SYMS loads -> PAYLOAD.
//  FSM PAYLOAD: s_ready = (half==0) || slot free.
//   First bit of pair: stored in half register, no output.
//   Second bit: dibit loaded into output register next cycle (latency 1 clk from accept), m_pre=0.
//   s_last on second bit: m_last=1 on that symbol.
//   s_last on first bit (odd length): pad missing bit with 0, emit immediately with m_last=1.
//   Loading the m_last symbol: frame_cnt++, FSM -> IDLE; next frame preamble starts after that.
//  Simultaneous m_ready and new load: old symbol retires, new one loads same edge, no bubble.
//  s_last with no preceding preamble impossible; s_valid deasserted mid-pair keeps half bit indefinitely.
// CONFIGURATION
//  QPSK_PACKER_GRAY_EN defined: payload dibit {b1,b0} emitted as {b1, b1^b0} (Gray mapping).
//   Preamble symbols and pad bit position unaffected.
//  Undefined: payload dibit emitted natural-binary, no extra logic.
// STRUCTURE
//  Package qpsk_pkg: typedef logic [1:0] dibit_t; enum {ST_IDLE,ST_PREAMBLE,ST_PAYLOAD} pack_state_t;
//   constants PRE_SYM_A=2'b00, PRE_SYM_B=2'b11.
//  Sub-module qpsk_out_reg: single-entry valid/ready output register carrying {dibit,last,pre}.
//  Top holds FSM, half-bit register, preamble and frame counters.
// TESTING
//  1. Frame bits 1,0,1,1 (last on 4th), m_ready=1 -> dibits 00,11,00,11 (m_pre=1) then 10,11 (last); frame_cnt=1.
//  2. Odd frame 1,1,0 (last on 3rd) -> payload 11 then 00 with m_last=1 (pad 0); MSB_FIRST=0 variant gives 11,00.
//  3. m_ready held low 5 cycles mid-payload -> m_dibit/m_last stable, s_ready=0 once half bit held.
//  4. Reset asserted after first bit of pair -> next cycle all outputs 0, state IDLE; new frame restarts preamble.
//  5. Gray build: payload bits 1,0 then 1,1 -> dibits 11, 10; preamble still 00,11,00,11.
//  6. Back-to-back frames, continuous valid/ready -> one symbol per cycle, no bubble between frames.

Source files
------------

// File: rtl/qpsk_symbol_packer_pkg.sv
// qpsk_pkg: shared types and constants for the QPSK symbol packer.
package qpsk_pkg;

   typedef logic [1:0] dibit_t;

   typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_PAYLOAD} pack_state_t;

   localparam dibit_t PRE_SYM_A = 2'b00;
   localparam dibit_t PRE_SYM_B = 2'b11;

   typedef struct packed {
      dibit_t dibit;
      logic   last;
      logic   pre;
   } sym_t;

   function automatic dibit_t pack_pair(input logic first, input logic second, input logic msb_first);
      return msb_first ? {first, second} : {second, first};
   endfunction

endpackage

// File: rtl/qpsk_symbol_packer_out_reg.sv
// qpsk_out_reg: single-entry valid/ready output register carrying {dibit,last,pre}.
module qpsk_out_reg
   import qpsk_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  sym_t sym_i,
   input  logic ready_i,
   output logic valid_o,
   output sym_t sym_o,
   output logic free_o
);

   logic valid_q;
   sym_t sym_q;

   assign free_o  = !valid_q || ready_i;
   assign valid_o = valid_q;
   assign sym_o   = sym_q;

   // load_i is only raised by the producer while free_o is high
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         sym_q   <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         sym_q   <= sym_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/qpsk_symbol_packer.sv
// qpsk_symbol_packer: prepends a preamble to each frame and packs serial bits into dibits.
// Define QPSK_PACKER_GRAY_EN to emit payload dibits Gray-mapped ({b1, b1^b0}).
module qpsk_symbol_packer
   import qpsk_pkg::*;
#(
   parameter int PREAMBLE_SYMS = 4,
   parameter bit MSB_FIRST     = 1'b1,
   parameter int FCNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              s_bit,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [1:0]        m_dibit,
   output logic              m_last,
   output logic              m_pre,
   output logic [FCNT_W-1:0] frame_cnt
);

   localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_SYMS - 1);

   pack_state_t       state_q, state_d;
   logic              half_q, half_d;
   logic              hbit_q, hbit_d;
   logic              lpend_q, lpend_d;
   logic [3:0]        pcnt_q, pcnt_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              slot_free, load, fin, s_fire;
   sym_t              sym, out_sym;

   function automatic dibit_t map_pay(input dibit_t d);
`ifdef QPSK_PACKER_GRAY_EN
      return {d[1], d[1] ^ d[0]};
`else
      return d;
`endif
   endfunction

   // lpend_q: odd-length frame whose padded symbol is waiting for a free slot
   assign s_ready = (state_q == ST_PAYLOAD) && !lpend_q && (!half_q || slot_free);
   assign s_fire  = s_valid && s_ready;

   always_comb begin
      state_d = state_q;
      half_d  = half_q;
      hbit_d  = hbit_q;
      lpend_d = lpend_q;
      pcnt_d  = pcnt_q;
      fcnt_d  = fcnt_q;
      load    = 1'b0;
      fin     = 1'b0;
      sym     = '0;
      if (state_q == ST_IDLE && s_valid)
         state_d = ST_PREAMBLE;
      // the first preamble symbol loads straight from IDLE so frames follow without a bubble
      if (slot_free && (state_q == ST_PREAMBLE || (state_q == ST_IDLE && s_valid))) begin
         load   = 1'b1;
         sym    = '{dibit: pcnt_q[0] ? PRE_SYM_B : PRE_SYM_A, last: 1'b0, pre: 1'b1};
         pcnt_d = (pcnt_q == PRE_LAST) ? 4'd0 : pcnt_q + 4'd1;
         if (pcnt_q == PRE_LAST)
            state_d = ST_PAYLOAD;
      end
      if (state_q == ST_PAYLOAD) begin
         if (half_q) begin
            if (lpend_q ? slot_free : s_fire) begin
               load   = 1'b1;
               sym    = '{dibit: map_pay(pack_pair(hbit_q, lpend_q ? 1'b0 : s_bit, MSB_FIRST)),
                          last: lpend_q || s_last, pre: 1'b0};
               half_d = 1'b0;
               fin    = lpend_q || s_last;
            end
         end else if (s_fire) begin
            if (s_last && slot_free) begin
               load = 1'b1;
               sym  = '{dibit: map_pay(pack_pair(s_bit, 1'b0, MSB_FIRST)), last: 1'b1, pre: 1'b0};
               fin  = 1'b1;
            end else begin
               half_d  = 1'b1;
               hbit_d  = s_bit;
               lpend_d = s_last;
            end
         end
      end
      if (fin) begin
         fcnt_d  = fcnt_q + 1'b1;
         state_d = ST_IDLE;
         half_d  = 1'b0;
         lpend_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         half_q  <= 1'b0;
         hbit_q  <= 1'b0;
         lpend_q <= 1'b0;
         pcnt_q  <= '0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         half_q  <= half_d;
         hbit_q  <= hbit_d;
         lpend_q <= lpend_d;
         pcnt_q  <= pcnt_d;
         fcnt_q  <= fcnt_d;
      end
   end

   qpsk_out_reg u_out (
      .clk    (clk),
      .reset  (reset),
      .load_i (load),
      .sym_i  (sym),
      .ready_i(m_ready),
      .valid_o(m_valid),
      .sym_o  (out_sym),
      .free_o (slot_free)
   );

   assign m_dibit   = out_sym.dibit;
   assign m_last    = out_sym.last;
   assign m_pre     = out_sym.pre;
   assign frame_cnt = fcnt_q;

endmodule
